// File: rtl/sram_wordline_sequencer_pkg.sv
// Shared types and sizing helpers for the SRAM2 word-line sequencer.
//   state_e   : access FSM states
//   clog2_u   : ceiling log2 used for counter sizing
//   max_u     : maximum of two unsigned parameters
package sram_wordline_sequencer_pkg;

  localparam int unsigned SRAM_ADDR_W = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRECH   = 3'd1,
    WL_ON   = 3'd2,
    RECOVER = 3'd3,
    ERR     = 3'd4
  } state_e;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_wordline_sequencer_if.sv
// Request/word-line bundle between the SRAM2 controller and the sequencer.
//   req_valid/req_ready/req_addr : row access handshake
//   wl_out                       : one-hot word lines to the bit-cell array
//   precharge, busy, done, addr_err : status / array control
// master = controller side, slave = sequencer side.
interface sram_wordline_sequencer_if
  import sram_wordline_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W   = SRAM_ADDR_W,
  parameter int unsigned NUM_ROWS = 1024
);

  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic [NUM_ROWS-1:0] wl_out;
  logic                precharge;
  logic                busy;
  logic                done;
  logic                addr_err;

  modport master (
    output req_valid, req_addr,
    input  req_ready, wl_out, precharge, busy, done, addr_err
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, wl_out, precharge, busy, done, addr_err
  );

endinterface

// File: rtl/sram_wordline_sequencer_row_decode.sv
// Combinational row decoder: address -> one-hot row select plus range flag.
//   addr_i          : row address
//   onehot_c_o      : one-hot row select (all-zero when out of range)
//   in_range_c_o    : address < NUM_ROWS
module sram_wordline_sequencer_row_decode #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned NUM_ROWS = 1024
) (
  input  logic [ADDR_W-1:0]   addr_i,
  output logic [NUM_ROWS-1:0] onehot_c_o,
  output logic                in_range_c_o
);

  assign in_range_c_o = ({1'b0, addr_i} < (ADDR_W + 1)'(NUM_ROWS));

  // Compare against every present row; rows beyond NUM_ROWS simply never match.
  always_comb begin
    onehot_c_o = '0;
    for (int i = 0; i < int'(NUM_ROWS); i++) begin
      onehot_c_o[i] = (addr_i == ADDR_W'(i));
    end
  end

endmodule

// File: rtl/sram_wordline_sequencer.sv
// Word-line sequencer for the SRAM2 array. One access per accepted request:
// precharge (PRECH_CYC cycles), one-hot word line (WL_CYC cycles), one
// recovery cycle with done. Out-of-range addresses take a single ERR cycle.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of sram_wordline_sequencer_if
module sram_wordline_sequencer
  import sram_wordline_sequencer_pkg::*;
#(
  parameter int unsigned ADDR_W    = SRAM_ADDR_W,
  parameter int unsigned NUM_ROWS  = 1024,
  parameter int unsigned PRECH_CYC = 1,
  parameter int unsigned WL_CYC    = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  sram_wordline_sequencer_if.slave    bus
);

  localparam int unsigned CNT_W = clog2_u(max_u(PRECH_CYC, WL_CYC) + 1);
  localparam logic [CNT_W-1:0] PRECH_LOAD = CNT_W'(PRECH_CYC - 1);
  localparam logic [CNT_W-1:0] WL_LOAD    = CNT_W'(WL_CYC - 1);

  // Elaboration-time parameter sanity.
  if (PRECH_CYC == 0) begin : g_bad_prech
    $error("PRECH_CYC must be >= 1");
  end
  if (WL_CYC == 0) begin : g_bad_wl
    $error("WL_CYC must be >= 1");
  end
  if (NUM_ROWS == 0 || NUM_ROWS > (1 << ADDR_W)) begin : g_bad_rows
    $error("NUM_ROWS must be in 1 .. 2**ADDR_W");
  end

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [NUM_ROWS-1:0] wl_q, wl_d;
  logic                precharge_q, precharge_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                addr_err_q, addr_err_d;

  logic [ADDR_W-1:0]   dec_addr_c;
  logic [NUM_ROWS-1:0] dec_onehot_c;
  logic                dec_in_range_c;

  // In IDLE the decoder range-checks the incoming address; otherwise it
  // decodes the latched row so req_addr changes cannot reach the word lines.
  assign dec_addr_c = (state_q == IDLE) ? bus.req_addr : addr_q;

  sram_wordline_sequencer_row_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_ROWS (NUM_ROWS)
  ) u_row_decode (
    .addr_i       (dec_addr_c),
    .onehot_c_o   (dec_onehot_c),
    .in_range_c_o (dec_in_range_c)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d = bus.req_addr;
          if (dec_in_range_c) begin
            state_d = PRECH;
            cnt_d   = PRECH_LOAD;
          end else begin
            state_d = ERR;
          end
        end
      end
      PRECH: begin
        if (cnt_q == '0) begin
          state_d = WL_ON;
          cnt_d   = WL_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      WL_ON: begin
        if (cnt_q == '0) state_d = RECOVER;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RECOVER: state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are a function of the state being entered, so every output
    // is a flop and lines up with the state it describes.
    precharge_d = (state_d == PRECH);
    wl_d        = (state_d == WL_ON) ? dec_onehot_c : '0;
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == RECOVER) || (state_d == ERR);
    addr_err_d  = (state_d == ERR);
  end

  // State and output registers; reset clears word lines without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wl_q        <= '0;
      precharge_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wl_q        <= wl_d;
      precharge_q <= precharge_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      addr_err_q  <= addr_err_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.wl_out    = wl_q;
  assign bus.precharge = precharge_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.addr_err  = addr_err_q;

endmodule

// File: tb/tb_sram_wordline_sequencer.sv
// Bench for sram_wordline_sequencer: three instances (default, 1000 rows,
// PRECH_CYC=3/WL_CYC=4) with per-instance expectation queues.
module tb_sram_wordline_sequencer;

  typedef struct {
    logic [9:0] addr;
    logic       err;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  exp_t sb_d[$];
  exp_t sb_n[$];
  exp_t sb_l[$];

  sram_wordline_sequencer_if #(.ADDR_W(10), .NUM_ROWS(1024)) bus_d ();
  sram_wordline_sequencer_if #(.ADDR_W(10), .NUM_ROWS(1000)) bus_n ();
  sram_wordline_sequencer_if #(.ADDR_W(10), .NUM_ROWS(1024)) bus_l ();

  sram_wordline_sequencer #(.ADDR_W(10), .NUM_ROWS(1024), .PRECH_CYC(1), .WL_CYC(2)) u_d (
    .clk(clk), .rst_n(rst_n), .bus(bus_d));
  sram_wordline_sequencer #(.ADDR_W(10), .NUM_ROWS(1000), .PRECH_CYC(1), .WL_CYC(2)) u_n (
    .clk(clk), .rst_n(rst_n), .bus(bus_n));
  sram_wordline_sequencer #(.ADDR_W(10), .NUM_ROWS(1024), .PRECH_CYC(3), .WL_CYC(4)) u_l (
    .clk(clk), .rst_n(rst_n), .bus(bus_l));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lowest set row, -1 when all word lines are low.
  function automatic int row_of(input logic [1023:0] v);
    for (int i = 0; i < 1024; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus_d.wl_out !== '0)     begin errors++; $display("FAIL reset_wl got row %0d exp -1", row_of(bus_d.wl_out)); end
    checks++; if (bus_d.precharge !== 1'b0) begin errors++; $display("FAIL reset_precharge got %b exp 0", bus_d.precharge); end
    checks++; if (bus_d.busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b exp 0", bus_d.busy); end
    checks++; if (bus_d.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", bus_d.req_ready); end
    checks++; if (bus_d.done !== 1'b0 || bus_d.addr_err !== 1'b0) begin
      errors++; $display("FAIL reset_done got %b/%b exp 0/0", bus_d.done, bus_d.addr_err); end
    checks++; if (bus_l.req_ready !== 1'b1 || bus_n.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready_others got %b/%b exp 1/1", bus_l.req_ready, bus_n.req_ready); end
  endtask

  // Default timing: precharge c1, word line c2-3, done c4, ready c5.
  task automatic test_legal_access();
    logic [9:0] addrs [2];
    int   r, n, exp_row;
    exp_t e;
    addrs[0] = 10'h2A5;
    addrs[1] = 10'd1023;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus_d.req_valid = 1'b1;
      bus_d.req_addr  = addrs[k];
      checks++; if (bus_d.req_ready !== 1'b1) begin errors++; $display("FAIL legal_pre_ready got %b exp 1", bus_d.req_ready); end
      e.addr = addrs[k]; e.err = 1'b0; sb_d.push_back(e);
      @(posedge clk); #1;
      bus_d.req_valid = 1'b0;
      bus_d.req_addr  = 10'h155;
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        r = row_of(bus_d.wl_out); n = $countones(bus_d.wl_out);
        exp_row = (c == 2 || c == 3) ? int'(addrs[k]) : -1;
        checks++; if (r != exp_row || n > 1) begin errors++; $display("FAIL legal_wl a=%0d c=%0d got row %0d (ones %0d) exp %0d", addrs[k], c, r, n, exp_row); end
        checks++; if (bus_d.precharge !== (c == 1)) begin errors++; $display("FAIL legal_precharge c=%0d got %b exp %b", c, bus_d.precharge, c == 1); end
        checks++; if (bus_d.done !== (c == 4)) begin errors++; $display("FAIL legal_done c=%0d got %b exp %b", c, bus_d.done, c == 4); end
        checks++; if (bus_d.req_ready !== (c == 5)) begin errors++; $display("FAIL legal_ready c=%0d got %b exp %b", c, bus_d.req_ready, c == 5); end
        checks++; if (bus_d.busy !== (c <= 4)) begin errors++; $display("FAIL legal_busy c=%0d got %b exp %b", c, bus_d.busy, c <= 4); end
        if (bus_d.done === 1'b1) begin
          checks++;
          if (sb_d.size() == 0) begin errors++; $display("FAIL legal_sb unexpected done got 1 exp 0"); end
          else begin e = sb_d.pop_front(); if (bus_d.addr_err !== e.err) begin errors++; $display("FAIL legal_err got %b exp %b", bus_d.addr_err, e.err); end end
        end
      end
    end
  endtask

  // 1000-row instance: rows 999 / 0 legal, 1000 / 1010 rejected in cycle 1.
  task automatic test_illegal_addr();
    logic [9:0] addrs [4];
    logic [1023:0] w;
    int   r, exp_row;
    logic ill;
    exp_t e;
    addrs[0] = 10'd1010; addrs[1] = 10'd999; addrs[2] = 10'd1000; addrs[3] = 10'd0;
    for (int k = 0; k < 4; k++) begin
      ill = (addrs[k] >= 10'd1000);
      @(negedge clk);
      bus_n.req_valid = 1'b1;
      bus_n.req_addr  = addrs[k];
      e.addr = addrs[k]; e.err = ill; sb_n.push_back(e);
      @(posedge clk); #1;
      bus_n.req_valid = 1'b0;
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        w = 1024'(bus_n.wl_out); r = row_of(w);
        exp_row = (!ill && (c == 2 || c == 3)) ? int'(addrs[k]) : -1;
        checks++; if (r != exp_row || $countones(w) > 1) begin errors++; $display("FAIL range_wl a=%0d c=%0d got row %0d exp %0d", addrs[k], c, r, exp_row); end
        checks++; if (bus_n.precharge !== (!ill && c == 1)) begin errors++; $display("FAIL range_precharge a=%0d c=%0d got %b", addrs[k], c, bus_n.precharge); end
        checks++; if (bus_n.done !== (ill ? (c == 1) : (c == 4))) begin errors++; $display("FAIL range_done a=%0d c=%0d got %b", addrs[k], c, bus_n.done); end
        checks++; if (bus_n.req_ready !== (ill ? (c >= 2) : (c == 5))) begin errors++; $display("FAIL range_ready a=%0d c=%0d got %b", addrs[k], c, bus_n.req_ready); end
        checks++; if (bus_n.addr_err !== (ill && c == 1)) begin errors++; $display("FAIL range_addr_err a=%0d c=%0d got %b exp %b", addrs[k], c, bus_n.addr_err, ill && c == 1); end
        if (bus_n.done === 1'b1) begin
          checks++;
          if (sb_n.size() == 0) begin errors++; $display("FAIL range_sb unexpected done got 1 exp 0"); end
          else begin e = sb_n.pop_front(); if (bus_n.addr_err !== e.err) begin errors++; $display("FAIL range_sb_err got %b exp %b", bus_n.addr_err, e.err); end end
        end
      end
    end
  endtask

  // req_valid held high: rows 5 then 6, accepts 5 edges apart.
  task automatic test_back_to_back();
    int acc_edge[$];
    int r, last5, first6, nacc;
    logic acc;
    exp_t e;
    last5 = -1; first6 = -1; nacc = 0;
    @(negedge clk);
    bus_d.req_valid = 1'b1;
    bus_d.req_addr  = 10'd5;
    for (int i = 0; i < 14; i++) begin
      if (i > 0) @(negedge clk);
      r = row_of(bus_d.wl_out);
      checks++; if ($countones(bus_d.wl_out) > 1) begin errors++; $display("FAIL b2b_onehot c=%0d got %0d ones exp <=1", i, $countones(bus_d.wl_out)); end
      if (r == 5) last5 = i;
      if (r == 6 && first6 < 0) first6 = i;
      if (r >= 0 && sb_d.size() > 0) begin
        checks++; if (r != int'(sb_d[0].addr)) begin errors++; $display("FAIL b2b_row c=%0d got %0d exp %0d", i, r, sb_d[0].addr); end
      end
      if (bus_d.done === 1'b1) begin
        checks++;
        if (sb_d.size() == 0) begin errors++; $display("FAIL b2b_sb unexpected done got 1 exp 0"); end
        else begin e = sb_d.pop_front(); if (bus_d.addr_err !== e.err) begin errors++; $display("FAIL b2b_err got %b exp %b", bus_d.addr_err, e.err); end end
      end
      acc = bus_d.req_valid && bus_d.req_ready;
      if (acc) begin
        acc_edge.push_back(i);
        e.addr = bus_d.req_addr; e.err = 1'b0; sb_d.push_back(e);
      end
      @(posedge clk); #1;
      if (acc) begin
        nacc++;
        if (nacc == 1) bus_d.req_addr = 10'd6;
        else           bus_d.req_valid = 1'b0;
      end
    end
    checks++; if (acc_edge.size() != 2) begin errors++; $display("FAIL b2b_accepts got %0d exp 2", acc_edge.size()); end
    else begin
      checks++; if (acc_edge[1] - acc_edge[0] != 5) begin errors++; $display("FAIL b2b_period got %0d exp 5", acc_edge[1] - acc_edge[0]); end
    end
    checks++; if (last5 != 3 || first6 != 7) begin errors++; $display("FAIL b2b_windows got last5=%0d first6=%0d exp 3/7", last5, first6); end
    checks++; if (first6 - last5 < 2) begin errors++; $display("FAIL b2b_gap got %0d exp >=2", first6 - last5); end
    checks++; if (sb_d.size() != 0) begin errors++; $display("FAIL b2b_sb_drain got %0d exp 0", sb_d.size()); end
  endtask

  // Reset asserted while row 3 is driven clears it without a clock edge.
  task automatic test_reset_mid_access();
    exp_t e;
    @(negedge clk);
    bus_d.req_valid = 1'b1;
    bus_d.req_addr  = 10'd3;
    e.addr = 10'd3; e.err = 1'b0; sb_d.push_back(e);
    @(posedge clk); #1;
    bus_d.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (row_of(bus_d.wl_out) != 3) begin errors++; $display("FAIL rstmid_pre_wl got row %0d exp 3", row_of(bus_d.wl_out)); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus_d.wl_out !== '0) begin errors++; $display("FAIL rstmid_wl got row %0d exp -1", row_of(bus_d.wl_out)); end
    checks++; if (bus_d.precharge !== 1'b0 || bus_d.busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_flags got prech=%b busy=%b exp 0/0", bus_d.precharge, bus_d.busy); end
    sb_d.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus_d.req_ready !== 1'b1 || bus_d.busy !== 1'b0 || bus_d.wl_out !== '0) begin
      errors++; $display("FAIL rstmid_idle got ready=%b busy=%b row=%0d exp 1/0/-1", bus_d.req_ready, bus_d.busy, row_of(bus_d.wl_out)); end
  endtask

  // PRECH_CYC=3, WL_CYC=4, row 0: precharge c1-3, word line c4-7, done c8, ready c9.
  task automatic test_long_timing();
    int r;
    exp_t e;
    @(negedge clk);
    bus_l.req_valid = 1'b1;
    bus_l.req_addr  = 10'd0;
    e.addr = 10'd0; e.err = 1'b0; sb_l.push_back(e);
    @(posedge clk); #1;
    bus_l.req_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      r = row_of(bus_l.wl_out);
      checks++; if (r != ((c >= 4 && c <= 7) ? 0 : -1)) begin errors++; $display("FAIL long_wl c=%0d got row %0d", c, r); end
      checks++; if (bus_l.precharge !== (c <= 3)) begin errors++; $display("FAIL long_precharge c=%0d got %b exp %b", c, bus_l.precharge, c <= 3); end
      checks++; if (bus_l.done !== (c == 8)) begin errors++; $display("FAIL long_done c=%0d got %b exp %b", c, bus_l.done, c == 8); end
      checks++; if (bus_l.req_ready !== (c == 9)) begin errors++; $display("FAIL long_ready c=%0d got %b exp %b", c, bus_l.req_ready, c == 9); end
      if (bus_l.done === 1'b1) begin
        checks++;
        if (sb_l.size() == 0) begin errors++; $display("FAIL long_sb unexpected done got 1 exp 0"); end
        else begin e = sb_l.pop_front(); if (bus_l.addr_err !== e.err) begin errors++; $display("FAIL long_err got %b exp %b", bus_l.addr_err, e.err); end end
      end
    end
  endtask

  // Random traffic on the long instance with per-cycle invariant checks.
  task automatic test_random_invariants();
    logic [1023:0] w, prev;
    int   r, n, pc, wc, ndone;
    exp_t e;
    prev = '0; pc = 0; wc = 0; ndone = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      w = bus_l.wl_out; r = row_of(w); n = $countones(w);
      checks++; if (n > 1) begin errors++; $display("FAIL rnd_onehot i=%0d got %0d ones exp <=1", i, n); end
      checks++; if (bus_l.precharge === 1'b1 && n != 0) begin errors++; $display("FAIL rnd_overlap i=%0d got prech=1 row %0d exp no row", i, r); end
      checks++; if (prev != '0 && w != '0 && w != prev) begin errors++; $display("FAIL rnd_bbm i=%0d got row %0d after %0d exp gap", i, r, row_of(prev)); end
      if (bus_l.precharge === 1'b1) pc++;
      if (n != 0) wc++;
      if (n != 0 && sb_l.size() > 0) begin
        checks++; if (r != int'(sb_l[0].addr)) begin errors++; $display("FAIL rnd_row i=%0d got %0d exp %0d", i, r, sb_l[0].addr); end
      end
      if (bus_l.done === 1'b1) begin
        ndone++;
        checks++;
        if (sb_l.size() == 0) begin errors++; $display("FAIL rnd_sb unexpected done got 1 exp 0"); end
        else begin e = sb_l.pop_front(); if (bus_l.addr_err !== e.err) begin errors++; $display("FAIL rnd_err got %b exp %b", bus_l.addr_err, e.err); end end
        checks++; if (pc != 3 || wc != 4) begin errors++; $display("FAIL rnd_lengths got prech=%0d wl=%0d exp 3/4", pc, wc); end
        pc = 0; wc = 0;
      end
      prev = w;
      bus_l.req_valid = (i < 380) && ($urandom_range(0, 3) != 0);
      bus_l.req_addr  = 10'($urandom_range(0, 1023));
      if (bus_l.req_valid && bus_l.req_ready) begin
        e.addr = bus_l.req_addr; e.err = 1'b0; sb_l.push_back(e);
      end
    end
    checks++; if (sb_l.size() != 0) begin errors++; $display("FAIL rnd_drain got %0d pending exp 0", sb_l.size()); end
    checks++; if (ndone < 20) begin errors++; $display("FAIL rnd_activity got %0d accesses exp >=20", ndone); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0;
    bus_d.req_valid = 1'b0; bus_d.req_addr = '0;
    bus_n.req_valid = 1'b0; bus_n.req_addr = '0;
    bus_l.req_valid = 1'b0; bus_l.req_addr = '0;
    #12 rst_n = 1'b1;
    test_reset();
    test_legal_access();
    test_illegal_addr();
    test_back_to_back();
    test_reset_mid_access();
    test_long_timing();
    test_random_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
